fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/fifo_uart_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_PRESCALE_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // data_xor is the XOR-reduction of the frame payload
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: pulses bit_done on the last clock of each serial bit.
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic [PRESCALE_WIDTH-1:0] i_period,
    output logic                      o_bit_done
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      last;

    assign last = (cnt_q == i_period - ONE);

    // load holds the counter at zero so the first bit starts from a clean count
    always_comb begin
        cnt_d = cnt_q + ONE;
        if (i_load || last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_done = last && !i_load;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a first-word-fall-through FIFO and
// serializes them as start / data (LSB first) / optional parity / stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [DATA_WIDTH-1:0]     i_fifo_data,
    input  logic                      i_fifo_empty,
    output logic                      o_fifo_rinc,
    input  logic                      i_par_en,
    input  logic                      i_par_typ,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tx,
    output logic                      o_busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
    localparam logic [PRESCALE_WIDTH-1:0] MIN_PER  = PRESCALE_WIDTH'(1);

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      data_xor_q, data_xor_d;
    logic                      tx_q, tx_d;
    logic                      rinc;
    logic                      timer_load;
    logic                      bit_done;
    logic [DATA_WIDTH-1:0]     shift_nxt;

    assign shift_nxt  = shift_q >> 1;
    assign timer_load = (state_q == IDLE);

    uart_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (timer_load),
        .i_period  (period_q),
        .o_bit_done(bit_done)
    );

    // tx_d is the line level for the state being entered, so o_tx is a pure flop
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        period_d   = period_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        data_xor_d = data_xor_q;
        tx_d       = tx_q;
        rinc       = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!i_fifo_empty) begin
                    rinc       = 1'b1;
                    shift_d    = i_fifo_data;
                    data_xor_d = ^i_fifo_data;
                    par_en_d   = i_par_en;
                    par_typ_d  = i_par_typ;
                    period_d   = (i_prescale == '0) ? MIN_PER : i_prescale;
                    idx_d      = '0;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            tx_d    = parity_bit(data_xor_q, par_typ_q);
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        shift_d = shift_nxt;
                        tx_d    = shift_nxt[0];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            period_q   <= MIN_PER;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            data_xor_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            period_q   <= period_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            data_xor_q <= data_xor_d;
            tx_q       <= tx_d;
        end
    end

    // reset masks the pop strobe even though the FSM may still read IDLE
    assign o_fifo_rinc = rinc && !i_rst;
    assign o_tx        = tx_q;
    assign o_busy      = (state_q != IDLE);

endmodule
